rob_alloc: RTL and testbench

In-order ROB slot allocator: the issue-side counterpart of the reorder buffer's completion ports. It hands out `robIdx` tags to instructions leaving decode, tracks which slots are allocated and still awaiting completion on the three completion ports, and frees slots as the ROB commits its head. It sits between decode and the execution ports and provides the full/stall signal that back-pressures decode.

---
 rtl/rob_alloc.sv | 131 +++++++++++++
 tb/tb_rob_alloc.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_alloc.sv
// In-order ROB tag allocator: hands out tail tags, tracks per-slot allocated/pending
// state for three completion ports, frees the head on commit and flags protocol misuse.
module rob_alloc #(
  parameter int unsigned ROB_SLOTS    = 16,
  parameter int unsigned ROB_IDX_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    allocReq,
  output logic                    allocGnt,
  output logic [ROB_IDX_BITS-1:0] allocIdx,
  input  logic                    valid1,
  input  logic [ROB_IDX_BITS-1:0] robIdx1,
  input  logic                    valid2,
  input  logic [ROB_IDX_BITS-1:0] robIdx2,
  input  logic                    valid3,
  input  logic [ROB_IDX_BITS-1:0] robIdx3,
  input  logic                    commit,
  output logic [ROB_IDX_BITS-1:0] headIdx,
  output logic [ROB_IDX_BITS:0]   count,
  output logic                    full,
  output logic                    empty,
  output logic                    headDone,
  output logic                    error
);

  localparam int unsigned CW = ROB_IDX_BITS + 1;
  localparam int          NP = 3;

  logic [ROB_IDX_BITS-1:0] tail_q, tail_n, head_q, head_n;
  logic [CW-1:0]           count_q, count_n;
  logic [ROB_SLOTS-1:0]    alloc_q, alloc_n, pend_q, pend_n;
  logic                    full_q, full_n, empty_q, empty_n;
  logic                    head_done_q, head_done_n, error_q, error_n;
  logic                    do_commit;
  logic [NP-1:0]           cv;
  logic [ROB_IDX_BITS-1:0] ci [NP];

  assign cv    = {valid3, valid2, valid1};
  assign ci[0] = robIdx1;
  assign ci[1] = robIdx2;
  assign ci[2] = robIdx3;

  // Next-state: grant at tail, completions clear pend, commit frees head; clear wipes all but error.
  always_comb begin
    tail_n    = tail_q;
    head_n    = head_q;
    alloc_n   = alloc_q;
    pend_n    = pend_q;
    error_n   = error_q;
    allocGnt  = allocReq & ~full_q & ~clear & rst;
    do_commit = commit & ~empty_q & ~clear;

    if (allocGnt) begin
      alloc_n[tail_q] = 1'b1;
      pend_n[tail_q]  = 1'b1;
      tail_n          = tail_q + ROB_IDX_BITS'(1);
    end

    // Checks use pre-edge state, so a same-cycle grant looks unallocated.
    for (int i = 0; i < NP; i++) begin
      if (cv[i]) begin
        if (alloc_q[ci[i]] && pend_q[ci[i]]) pend_n[ci[i]] = 1'b0;
        else                                 error_n       = 1'b1;
        for (int j = i + 1; j < NP; j++) begin
          if (cv[j] && (ci[j] == ci[i])) error_n = 1'b1;
        end
      end
    end

    if (commit) begin
      if (empty_q) begin
        error_n = 1'b1;
      end else begin
        if (pend_q[head_q]) error_n = 1'b1;
        alloc_n[head_q] = 1'b0;
        pend_n[head_q]  = 1'b0;
        head_n          = head_q + ROB_IDX_BITS'(1);
      end
    end

    count_n = count_q + CW'(allocGnt) - CW'(do_commit);

    if (clear) begin
      tail_n  = '0;
      head_n  = '0;
      alloc_n = '0;
      pend_n  = '0;
      count_n = '0;
      error_n = error_q;
    end

    full_n      = (count_n == CW'(ROB_SLOTS));
    empty_n     = (count_n == '0);
    head_done_n = alloc_n[head_n] & ~pend_n[head_n];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tail_q      <= '0;
      head_q      <= '0;
      count_q     <= '0;
      alloc_q     <= '0;
      pend_q      <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      head_done_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      tail_q      <= tail_n;
      head_q      <= head_n;
      count_q     <= count_n;
      alloc_q     <= alloc_n;
      pend_q      <= pend_n;
      full_q      <= full_n;
      empty_q     <= empty_n;
      head_done_q <= head_done_n;
      error_q     <= error_n;
    end
  end

  assign allocIdx = tail_q;
  assign headIdx  = head_q;
  assign count    = count_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign headDone = head_done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_rob_alloc.sv
// Directed checks of rob_alloc plus a short random alloc/complete/commit run against a
// small reference model.
module tb_rob_alloc;

  logic       clk = 1'b0;
  logic       rst, clear, allocReq, commit;
  logic       valid1, valid2, valid3;
  logic [3:0] robIdx1, robIdx2, robIdx3;
  logic       allocGnt, full, empty, headDone, error;
  logic [3:0] allocIdx, headIdx;
  logic [4:0] count;

  int n_cmp = 0;
  int n_bad = 0;

  rob_alloc #(.ROB_SLOTS(16), .ROB_IDX_BITS(4)) dut (
    .clk(clk), .rst(rst), .clear(clear), .allocReq(allocReq),
    .allocGnt(allocGnt), .allocIdx(allocIdx),
    .valid1(valid1), .robIdx1(robIdx1),
    .valid2(valid2), .robIdx2(robIdx2),
    .valid3(valid3), .robIdx3(robIdx3),
    .commit(commit), .headIdx(headIdx), .count(count),
    .full(full), .empty(empty), .headDone(headDone), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    clear = 0; allocReq = 0; commit = 0;
    valid1 = 0; valid2 = 0; valid3 = 0;
    robIdx1 = '0; robIdx2 = '0; robIdx3 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 0;
    go();
    rst = 1;
  endtask

  // reference model state for the random run
  logic [15:0] m_alloc, m_pend;
  int          m_head, m_tail, m_count, m_commits, cycles, s, pick;
  logic        req, cmt, gnt_exp;

  initial begin
    idle_inputs();
    rst = 0;
    go(); go();
    rst = 1;

    // reset values and first grants
    mid();
    chk("rst_gnt", allocGnt, 0);  chk("rst_idx", allocIdx, 0);
    chk("rst_head", headIdx, 0);  chk("rst_count", count, 0);
    chk("rst_full", full, 0);     chk("rst_empty", empty, 1);
    chk("rst_hdone", headDone, 0); chk("rst_err", error, 0);
    go();
    allocReq = 1;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("seq_gnt", allocGnt, 1);
      chk("seq_idx", allocIdx, 32'(i));
      chk("seq_count", count, 32'(i));
      go();
    end

    // fill to full, commit+request while full, then slot 0 re-granted
    do_reset();
    allocReq = 1;
    for (int i = 0; i < 16; i++) begin
      mid();
      chk("fill_gnt", allocGnt, 1);
      chk("fill_idx", allocIdx, 32'(i));
      go();
    end
    commit = 1;
    mid();
    chk("full_count", count, 16); chk("full_flag", full, 1);
    chk("full_empty", empty, 0);  chk("full_nogrant", allocGnt, 0);
    go();
    commit = 0;
    mid();
    chk("refill_count", count, 15); chk("refill_full", full, 0);
    chk("refill_gnt", allocGnt, 1); chk("refill_idx", allocIdx, 0);
    chk("refill_head", headIdx, 1);
    chk("commit_pend_err", error, 1);
    go();

    // completion ordering and headDone
    do_reset();
    allocReq = 1;
    go(); go(); go();
    allocReq = 0;
    valid3 = 1; robIdx3 = 4'd2;
    go();
    valid3 = 0;
    mid(); chk("hd_after_slot2", headDone, 0);
    go();
    valid1 = 1; robIdx1 = 4'd0;
    go();
    valid1 = 0;
    mid(); chk("hd_after_slot0", headDone, 1); chk("hd_err", error, 0);
    go();
    commit = 1;
    go();
    commit = 0;
    mid();
    chk("hd_commit_head", headIdx, 1); chk("hd_commit_done", headDone, 0);
    chk("hd_commit_count", count, 2);  chk("hd_commit_err", error, 0);
    go();
    valid2 = 1; robIdx2 = 4'd1;
    go();
    valid2 = 0;
    mid(); chk("hd_slot1_done", headDone, 1);
    go();

    // error: completion to unallocated slot, sticky through clear
    do_reset();
    valid1 = 1; robIdx1 = 4'd5;
    mid(); chk("err_before", error, 0);
    go();
    valid1 = 0;
    mid(); chk("err_unalloc", error, 1);
    go();
    clear = 1;
    go();
    clear = 0;
    mid(); chk("err_sticky", error, 1); chk("err_clear_count", count, 0);
    go();

    // error: same slot on two ports; pend still cleared
    do_reset();
    allocReq = 1;
    go();
    allocReq = 0;
    valid1 = 1; robIdx1 = 4'd0; valid2 = 1; robIdx2 = 4'd0;
    go();
    valid1 = 0; valid2 = 0;
    mid(); chk("dup_err", error, 1); chk("dup_hdone", headDone, 1);
    go();

    // empty boundary: grant + commit with count 0
    do_reset();
    allocReq = 1; commit = 1;
    mid(); chk("emp_gnt", allocGnt, 1);
    go();
    allocReq = 0; commit = 0;
    mid(); chk("emp_count", count, 1); chk("emp_err", error, 1);
    chk("emp_head", headIdx, 0);
    go();

    // clear at occupancy 7 with head 3
    do_reset();
    allocReq = 1;
    repeat (10) go();
    allocReq = 0;
    valid1 = 1; robIdx1 = 4'd0; valid2 = 1; robIdx2 = 4'd1; valid3 = 1; robIdx3 = 4'd2;
    go();
    valid1 = 0; valid2 = 0; valid3 = 0;
    commit = 1;
    repeat (3) go();
    commit = 0;
    mid(); chk("occ_count", count, 7); chk("occ_head", headIdx, 3);
    chk("occ_tail", allocIdx, 10);     chk("occ_err", error, 0);
    go();
    clear = 1; allocReq = 1; commit = 1;
    mid(); chk("clr_nogrant", allocGnt, 0);
    go();
    clear = 0; allocReq = 0; commit = 0;
    mid();
    chk("clr_count", count, 0); chk("clr_head", headIdx, 0);
    chk("clr_idx", allocIdx, 0); chk("clr_empty", empty, 1);
    chk("clr_err", error, 0);
    go();

    // random transactions against the reference model
    do_reset();
    m_alloc = '0; m_pend = '0;
    m_head = 0; m_tail = 0; m_count = 0; m_commits = 0; cycles = 0;
    while (m_commits < 40 && cycles < 2000) begin
      cycles++;
      req = ($urandom_range(0, 99) < 55);
      valid1 = 0;
      pick = -1;
      if ($urandom_range(0, 1) == 1) begin
        s = $urandom_range(0, 15);
        for (int k = 0; k < 16; k++) begin
          if (pick < 0 && m_alloc[(s + k) % 16] && m_pend[(s + k) % 16]) pick = (s + k) % 16;
        end
      end
      if (pick >= 0) begin
        valid1 = 1; robIdx1 = 4'(pick);
      end
      cmt = (m_count > 0) && m_alloc[m_head] && !m_pend[m_head] && ($urandom_range(0, 2) != 0);
      allocReq = req; commit = cmt;
      gnt_exp = req && (m_count < 16);
      mid();
      chk("rnd_gnt", allocGnt, 32'(gnt_exp));
      chk("rnd_idx", allocIdx, 32'(m_tail));
      chk("rnd_head", headIdx, 32'(m_head));
      chk("rnd_count", count, 32'(m_count));
      chk("rnd_hdone", headDone, 32'(m_alloc[m_head] && !m_pend[m_head]));
      chk("rnd_err", error, 0);
      if (pick >= 0) m_pend[pick] = 1'b0;
      if (cmt) begin
        m_alloc[m_head] = 1'b0;
        m_head = (m_head + 1) % 16;
        m_count--;
        m_commits++;
      end
      if (gnt_exp) begin
        m_alloc[m_tail] = 1'b1;
        m_pend[m_tail] = 1'b1;
        m_tail = (m_tail + 1) % 16;
        m_count++;
      end
      go();
    end
    chk("rnd_budget", 32'(m_commits >= 40), 1);
    idle_inputs();
    mid();
    chk("rnd_final_count", count, 32'(m_count));
    chk("rnd_final_err", error, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
